// File: rtl/rega_pkg.sv
// Shared types and constants for the irrigation status LED matrix.
//   Defines the matrix geometry, the Nivel/Modo encodings, the scan state enum,
//   the image flag payload, and the status-to-flags decoder.
package rega_pkg;

    localparam int unsigned NUM_ROWS = 7;
    localparam int unsigned NUM_COLS = 5;
    localparam logic [2:0]  ROW_BLANK = 3'd7;

    localparam logic [1:0] NIVEL_CRITICO = 2'b00;
    localparam logic [1:0] NIVEL_BAIXO   = 2'b01;
    localparam logic [1:0] NIVEL_MEDIO   = 2'b10;
    localparam logic [1:0] NIVEL_ALTO    = 2'b11;

    localparam logic MODO_GOTEJAMENTO = 1'b0;
    localparam logic MODO_ASPERSAO    = 1'b1;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

    // Synchronised irrigation status as sampled from the async sources
    typedef struct packed {
        logic       modo;
        logic [1:0] nivel;
    } status_t;

    // One-hot image flags handed to the matrix driver
    typedef struct packed {
        logic critico;
        logic baixo;
        logic medio;
        logic alto;
        logic aspersao;
        logic gotejamento;
    } img_flags_t;

    // Status -> one level flag plus one mode flag
    function automatic img_flags_t decode_status(status_t s);
        img_flags_t f;
        f = '0;
        case (s.nivel)
            NIVEL_CRITICO: f.critico = 1'b1;
            NIVEL_BAIXO:   f.baixo   = 1'b1;
            NIVEL_MEDIO:   f.medio   = 1'b1;
            NIVEL_ALTO:    f.alto    = 1'b1;
        endcase
        f.aspersao    = (s.modo == MODO_ASPERSAO);
        f.gotejamento = (s.modo == MODO_GOTEJAMENTO);
        return f;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level inputs.
//   clk   : sampling clock
//   rst_n : async active-low reset, clears both stages
//   d     : asynchronous input bus
//   q     : synchronised output (two-cycle latency)
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/matriz_scan_ctrl.sv
// Row-scan timing and image source selection for the 7x5 LED matrix.
//   Clock, Reset_n   : system clock, async active-low reset
//   Enable           : 1 = scanning, 0 = blanked
//   Nivel, Modo      : async irrigation status (synchronised internally)
//   Clock_Linhas     : active row 0..6, 7 = blank
//   img_sel          : 0 = level image, 1 = mode image
//   Critico..Alto    : one-hot level flags, Aspersao/Gotejamento : mode flags
//   Frame_Start      : one-cycle pulse when row 0 becomes active
module matriz_scan_ctrl
    import rega_pkg::*;
#(
    parameter int unsigned ROW_DIV    = 50000,
    parameter int unsigned IMG_FRAMES = 128
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Enable,
    input  logic [1:0] Nivel,
    input  logic       Modo,
    output logic [2:0] Clock_Linhas,
    output logic       img_sel,
    output logic       Critico,
    output logic       Baixo,
    output logic       Medio,
    output logic       Alto,
    output logic       Aspersao,
    output logic       Gotejamento,
    output logic       Frame_Start
);

    localparam int unsigned PW = $clog2(ROW_DIV);
    localparam int unsigned FW = (IMG_FRAMES > 1) ? $clog2(IMG_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(ROW_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(IMG_FRAMES - 1);
    localparam logic [2:0]    ROW_LAST   = 3'(NUM_ROWS - 1);

    status_t status_s;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk   (Clock),
        .rst_n (Reset_n),
        .d     ({Modo, Nivel}),
        .q     (status_s)
    );

    scan_state_t   state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          img_q, img_d;
    logic          fs_q, fs_d;
    img_flags_t    flags_q, flags_d;

    // State and datapath registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= BLANK;
            row_q   <= ROW_BLANK;
            presc_q <= '0;
            fcnt_q  <= '0;
            img_q   <= 1'b0;
            fs_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            presc_q <= presc_d;
            fcnt_q  <= fcnt_d;
            img_q   <= img_d;
            fs_q    <= fs_d;
            flags_q <= flags_d;
        end
    end

    // Next-state: row stepping, frame wrap, image alternation, shadow reload
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        presc_d = presc_q;
        fcnt_d  = fcnt_q;
        img_d   = img_q;
        fs_d    = 1'b0;
        flags_d = flags_q;
        case (state_q)
            BLANK: begin
                row_d   = ROW_BLANK;
                presc_d = '0;
                fcnt_d  = '0;
                if (Enable) begin
                    state_d = SCAN;
                    row_d   = 3'd0;
                    fs_d    = 1'b1;
                    flags_d = decode_status(status_s);
                end
            end
            SCAN: begin
                // Disable wins over any row/frame tick on the same edge
                if (!Enable) begin
                    state_d = BLANK;
                    row_d   = ROW_BLANK;
                    presc_d = '0;
                    fcnt_d  = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = 3'd0;
                        fs_d    = 1'b1;
                        flags_d = decode_status(status_s);
                        if (fcnt_q == FRAME_LAST) begin
                            fcnt_d = '0;
                            img_d  = ~img_q;
                        end else begin
                            fcnt_d = fcnt_q + FW'(1);
                        end
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = BLANK;
                row_d   = ROW_BLANK;
            end
        endcase
    end

    assign Clock_Linhas = row_q;
    assign img_sel      = img_q;
    assign Frame_Start  = fs_q;
    assign Critico      = flags_q.critico;
    assign Baixo        = flags_q.baixo;
    assign Medio        = flags_q.medio;
    assign Alto         = flags_q.alto;
    assign Aspersao     = flags_q.aspersao;
    assign Gotejamento  = flags_q.gotejamento;

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Self-checking bench for matriz_scan_ctrl with ROW_DIV=4, IMG_FRAMES=2.
module tb_matriz_scan_ctrl;

    localparam int ROW_DIV    = 4;
    localparam int IMG_FRAMES = 2;
    localparam int FRAME_LEN  = 7 * ROW_DIV;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Enable = 1'b1;
    logic [1:0] Nivel = 2'b00;
    logic       Modo = 1'b0;
    logic [2:0] Clock_Linhas;
    logic       img_sel, Critico, Baixo, Medio, Alto, Aspersao, Gotejamento, Frame_Start;

    matriz_scan_ctrl #(.ROW_DIV(ROW_DIV), .IMG_FRAMES(IMG_FRAMES)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Enable       (Enable),
        .Nivel        (Nivel),
        .Modo         (Modo),
        .Clock_Linhas (Clock_Linhas),
        .img_sel      (img_sel),
        .Critico      (Critico),
        .Baixo        (Baixo),
        .Medio        (Medio),
        .Alto         (Alto),
        .Aspersao     (Aspersao),
        .Gotejamento  (Gotejamento),
        .Frame_Start  (Frame_Start)
    );

    always #5 Clock = ~Clock;

    wire [5:0] dut_flags = {Critico, Baixo, Medio, Alto, Aspersao, Gotejamento};

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected flags: one-hot level {Critico,Baixo,Medio,Alto} then {Aspersao,Gotejamento}
    function automatic logic [5:0] exp_flags(input logic [2:0] st);
        logic [3:0] lvl;
        lvl = 4'b1000 >> st[1:0];
        return {lvl, st[2], ~st[2]};
    endfunction

    // Model: scanning time since row 0 first lit; everything follows from it
    bit         m_run;
    int         m_t;
    logic       m_img;
    logic [5:0] m_flags;
    logic       m_fs;
    logic [2:0] h1, h2, synced;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_run = 1'b0; m_t = 0; m_img = 1'b0; m_flags = '0; m_fs = 1'b0;
            h1 = '0; h2 = '0;
        end else begin
            synced = h2;            // input value sampled two edges ago
            h2 = h1;
            h1 = {Modo, Nivel};
            m_fs = 1'b0;
            if (!m_run) begin
                if (Enable) begin
                    m_run = 1'b1; m_t = 0; m_fs = 1'b1; m_flags = exp_flags(synced);
                end
            end else if (!Enable) begin
                m_run = 1'b0;
            end else begin
                m_t++;
                if (m_t % FRAME_LEN == 0) begin
                    m_fs = 1'b1;
                    m_flags = exp_flags(synced);
                    if ((m_t / FRAME_LEN) % IMG_FRAMES == 0) m_img = ~m_img;
                end
            end
        end
    end

    function automatic logic [2:0] m_row();
        return m_run ? 3'((m_t / ROW_DIV) % 7) : 3'd7;
    endfunction

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge Clock) begin
        if (check_en) begin
            chk("row", 32'(Clock_Linhas), 32'(m_row()));
            chk("img_sel", 32'(img_sel), 32'(m_img));
            chk("flags", 32'(dut_flags), 32'(m_flags));
            chk("frame_start", 32'(Frame_Start), 32'(m_fs));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        // 1. reset and release
        tick(3);
        chk("rst_row", 32'(Clock_Linhas), 32'd7);
        chk("rst_flags", 32'(dut_flags), 32'd0);
        chk("rst_img", 32'(img_sel), 32'd0);
        chk("rst_fs", 32'(Frame_Start), 32'd0);
        Reset_n = 1'b1;
        check_en = 1'b1;
        tick(1);
        chk("entry_row", 32'(Clock_Linhas), 32'd0);
        chk("entry_fs", 32'(Frame_Start), 32'd1);
        chk("entry_flags", 32'(dut_flags), 32'b100001);
        // 2. row stepping and wrap
        tick(4);
        chk("row1", 32'(Clock_Linhas), 32'd1);
        chk("row1_fs", 32'(Frame_Start), 32'd0);
        tick(23);
        chk("row6", 32'(Clock_Linhas), 32'd6);
        tick(1);
        chk("wrap_row", 32'(Clock_Linhas), 32'd0);
        chk("wrap_fs", 32'(Frame_Start), 32'd1);
        chk("wrap_img", 32'(img_sel), 32'd0);
        // 3. img_sel alternation
        tick(27);
        chk("img_before", 32'(img_sel), 32'd0);
        tick(1);
        chk("img_toggle", 32'(img_sel), 32'd1);
        tick(56);
        chk("img_back", 32'(img_sel), 32'd0);
        chk("img_back_fs", 32'(Frame_Start), 32'd1);
        // 4. status change mid-frame (row 3)
        tick(12);
        chk("row3", 32'(Clock_Linhas), 32'd3);
        Nivel = 2'b10;
        Modo  = 1'b1;
        tick(15);
        chk("shadow_hold", 32'(dut_flags), 32'b100001);
        tick(1);
        chk("shadow_load", 32'(dut_flags), 32'b001010);
        chk("shadow_fs", 32'(Frame_Start), 32'd1);
        // 5. disable in row 4, then re-enable
        tick(16);
        chk("row4", 32'(Clock_Linhas), 32'd4);
        Enable = 1'b0;
        tick(1);
        chk("dis_row", 32'(Clock_Linhas), 32'd7);
        chk("dis_flags", 32'(dut_flags), 32'b001010);
        chk("dis_fs", 32'(Frame_Start), 32'd0);
        tick(2);
        Enable = 1'b1;
        tick(1);
        chk("reen_row", 32'(Clock_Linhas), 32'd0);
        chk("reen_fs", 32'(Frame_Start), 32'd1);
        tick(4);
        chk("reen_row1", 32'(Clock_Linhas), 32'd1);
        // 6a. async reset pulse mid-row 5, between edges
        tick(16);
        chk("row5", 32'(Clock_Linhas), 32'd5);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_row", 32'(Clock_Linhas), 32'd7);
        chk("async_flags", 32'(dut_flags), 32'd0);
        chk("async_img", 32'(img_sel), 32'd0);
        chk("async_fs", 32'(Frame_Start), 32'd0);
        #1 Reset_n = 1'b1;
        tick(1);
        // synchroniser was cleared, so the first frame shows the reset status
        chk("post_rst_flags", 32'(dut_flags), 32'b100001);
        chk("post_rst_row", 32'(Clock_Linhas), 32'd0);
        // 6b. disable exactly on the wrap edge
        tick(27);
        chk("pre_wrap_row", 32'(Clock_Linhas), 32'd6);
        Enable = 1'b0;
        tick(1);
        chk("wrap_dis_row", 32'(Clock_Linhas), 32'd7);
        chk("wrap_dis_fs", 32'(Frame_Start), 32'd0);
        chk("wrap_dis_flags", 32'(dut_flags), 32'b100001);
        Enable = 1'b1;
        tick(1);
        chk("final_row", 32'(Clock_Linhas), 32'd0);
        chk("final_flags", 32'(dut_flags), 32'b001010);
        tick(30);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
